// File: rtl/proc_host_seq_if.sv
// Bus interface between the host sequencer and its environment.
// Groups the source stream (in_*), result stream (out_*), the processor
// status handshake (status/proc_status) and the data-memory port (dm_*,
// host_own).
//   master : sequencer side (drives in_ready, out_*, status, host_own, dm_addr/wdata/we)
//   slave  : environment side (source, sink, processor, data memory)
interface proc_host_seq_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        status;
    logic [1:0]        proc_status;
    logic              host_own;
    logic [ADDR_W-1:0] dm_addr;
    logic [7:0]        dm_wdata;
    logic              dm_we;
    logic [7:0]        dm_rdata;

    modport master (
        input  in_data, in_valid, out_ready, proc_status, dm_rdata,
        output in_ready, out_data, out_valid, status, host_own,
               dm_addr, dm_wdata, dm_we
    );

    modport slave (
        output in_data, in_valid, out_ready, proc_status, dm_rdata,
        input  in_ready, out_data, out_valid, status, host_own,
               dm_addr, dm_wdata, dm_we
    );
endinterface

// File: rtl/proc_host_seq.sv
// Host-side sequencer for the downsampling processor.
// Loads a source image into data memory, requests a processor run, waits
// for running then idle, and streams the result region back out.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : pulse, starts a load/run/dump sequence (only seen in IDLE)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when the dump completes
//   err        : sticky start-timeout flag, cleared by the next accepted go
//   bus        : streams, processor handshake and data-memory port (master)
module proc_host_seq #(
    parameter int unsigned       ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] LOAD_LAST     = 16'd65535,
    parameter logic [ADDR_W-1:0] DUMP_BASE     = 16'd0,
    parameter logic [ADDR_W-1:0] DUMP_LAST     = 16'd16383,
    parameter int unsigned       START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    proc_host_seq_if.master        bus
);

    localparam int unsigned TMO_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DUMP_ADDR,
        S_DUMP_HOLD,
        S_FIN,
        S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [TMO_W-1:0]  tcnt;
    logic              in_ready_q;
    logic [1:0]        status_q;
    logic              host_own_q;
    logic              out_valid_q;
    logic [7:0]        out_data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // Write strobe follows the source handshake directly so a byte lands in
    // memory on the same edge it is accepted.
    assign bus.dm_we     = (state == S_LOAD) & bus.in_valid;
    assign bus.dm_addr   = addr;
    assign bus.dm_wdata  = bus.in_data;
    assign bus.in_ready  = in_ready_q;
    assign bus.status    = status_q;
    assign bus.host_own  = host_own_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // Sequencer FSM; every output register is updated on the transition
    // into the state that owns its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            tcnt        <= '0;
            in_ready_q  <= 1'b0;
            status_q    <= 2'b00;
            host_own_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state      <= S_LOAD;
                        addr       <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (addr == LOAD_LAST) begin
                            state      <= S_START;
                            in_ready_q <= 1'b0;
                            status_q   <= 2'b01;
                            host_own_q <= 1'b0;
                            tcnt       <= '0;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                S_START: begin
                    if (bus.proc_status == 2'b10) begin
                        state    <= S_RUN;
                        status_q <= 2'b00;
                        tcnt     <= '0;
                    end else if (tcnt == TMO_W'(START_TIMEOUT - 1)) begin
                        state      <= S_ERR;
                        status_q   <= 2'b00;
                        host_own_q <= 1'b1;
                        err_q      <= 1'b1;
                        tcnt       <= '0;
                    end else begin
                        tcnt <= tcnt + TMO_W'(1);
                    end
                end
                S_RUN: begin
                    if (bus.proc_status == 2'b00) begin
                        state      <= S_DUMP_ADDR;
                        addr       <= DUMP_BASE;
                        host_own_q <= 1'b1;
                    end
                end
                // Address was launched on entry; capture the read data now.
                S_DUMP_ADDR: begin
                    state       <= S_DUMP_HOLD;
                    out_data_q  <= bus.dm_rdata;
                    out_valid_q <= 1'b1;
                end
                S_DUMP_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (addr == DUMP_LAST) begin
                            state  <= S_FIN;
                            done_q <= 1'b1;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= S_DUMP_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ERR: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_host_seq.sv
// Self-checking bench for proc_host_seq: randomized source/result data and
// handshake timing, checked against a transaction-level expectation of the
// write sequence, the dump stream and the control outputs.
module tb_proc_host_seq;

    localparam int unsigned ADDR_W        = 16;
    localparam logic [15:0] LOAD_LAST     = 16'd3;
    localparam logic [15:0] DUMP_BASE     = 16'd8;
    localparam logic [15:0] DUMP_LAST     = 16'd10;
    localparam int unsigned START_TIMEOUT = 16;
    localparam int unsigned N_LOAD        = 4;
    localparam int unsigned N_DUMP        = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic go;
    logic busy;
    logic done;
    logic err;

    proc_host_seq_if #(.ADDR_W(ADDR_W)) bus ();

    proc_host_seq #(
        .ADDR_W        (ADDR_W),
        .LOAD_LAST     (LOAD_LAST),
        .DUMP_BASE     (DUMP_BASE),
        .DUMP_LAST     (DUMP_LAST),
        .START_TIMEOUT (START_TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: host writes while it owns the port, processor writes otherwise.
    logic [7:0] mem [16];
    logic       proc_we;
    logic [3:0] proc_addr;
    logic [7:0] proc_wdata;

    always @(posedge clk) begin
        if (bus.host_own && bus.dm_we)
            mem[bus.dm_addr[3:0]] <= bus.dm_wdata;
        else if (!bus.host_own && proc_we)
            mem[proc_addr] <= proc_wdata;
    end

    assign bus.dm_rdata = mem[bus.dm_addr[3:0]];

    // Expected payloads for the current sequence.
    logic [7:0] src [N_LOAD];
    logic [7:0] res [N_DUMP];

    // Passive monitor, sampled on the falling edge when everything is settled.
    int unsigned wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [7:0]  got_q [$];
    int unsigned hold_bad = 0;
    int unsigned own_bad  = 0;
    int unsigned we_bad   = 0;
    logic        prev_valid;
    logic        prev_ready;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            got_q.delete();
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 8'h00;
        end else begin
            if (go && !busy) begin
                wr_addr_q.delete();
                wr_data_q.delete();
                got_q.delete();
            end
            if (bus.dm_we) begin
                wr_addr_q.push_back(int'(bus.dm_addr));
                wr_data_q.push_back(bus.dm_wdata);
                if (!bus.in_ready) we_bad++;
            end
            if (bus.status == 2'b01 && bus.host_own) own_bad++;
            if (bus.out_valid && prev_valid && !prev_ready && bus.out_data != prev_data) hold_bad++;
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_status",    32'(bus.status),    32'd0);
        check_eq("rst_host_own",  32'(bus.host_own),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_dm_we",     32'(bus.dm_we),     32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("rst_busy",      32'(busy),          32'd0);
        check_eq("rst_done",      32'(done),          32'd0);
        check_eq("rst_err",       32'(err),           32'd0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < int'(N_LOAD); i++) src[i] = 8'($urandom);
        for (int i = 0; i < int'(N_DUMP); i++) res[i] = 8'($urandom);
    endtask

    // Feed the whole source image with optional valid gaps; ends in START.
    task automatic load_bytes(input bit force_gap);
        for (int i = 0; i < int'(N_LOAD); i++) begin
            if ((force_gap && i == 1) || $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = src[i];
            tick();
        end
        bus.in_valid = 1'b0;
        check_eq("load_ready_drop", 32'(bus.in_ready), 32'd0);
        check_eq("start_status",    32'(bus.status),   32'd1);
        check_eq("start_own",       32'(bus.host_own), 32'd0);
        check_eq("load_count",      32'(wr_addr_q.size()), 32'(N_LOAD));
        if (wr_addr_q.size() == N_LOAD) begin
            for (int i = 0; i < int'(N_LOAD); i++) begin
                check_eq("load_addr", 32'(wr_addr_q[i]), 32'(i));
                check_eq("load_data", 32'(wr_data_q[i]), 32'(src[i]));
            end
        end
    endtask

    // Processor side: acknowledge start, write results, report idle.
    task automatic run_proc(input int start_delay, input int run_len, input bit go_noise);
        repeat (start_delay) tick();
        check_eq("start_hold", 32'(bus.status), 32'd1);
        bus.proc_status = 2'b10;
        tick();
        check_eq("run_status", 32'(bus.status),   32'd0);
        check_eq("run_own",    32'(bus.host_own), 32'd0);
        for (int i = 0; i < run_len; i++) begin
            proc_we    = (i < int'(N_DUMP));
            proc_addr  = 4'(int'(DUMP_BASE) + i);
            proc_wdata = (i < int'(N_DUMP)) ? res[i] : 8'h00;
            go         = go_noise && (i == 0);
            tick();
        end
        go              = 1'b0;
        proc_we         = 1'b0;
        bus.proc_status = 2'b00;
        tick();
        check_eq("dump_own",        32'(bus.host_own), 32'd1);
        check_eq("dump_first_addr", 32'(bus.dm_addr),  32'(DUMP_BASE));
    endtask

    // Sink side with random back-pressure; bounded wait for done.
    task automatic run_dump(input bit stall_second, input bit go_noise);
        int dcount = 0;
        int post   = 0;
        int stall  = 0;
        for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
            if (stall_second && got_q.size() == 1 && bus.out_valid && stall < 4) begin
                bus.out_ready = 1'b0;
                stall++;
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            go = go_noise && (cyc == 2);
            tick();
            if (done) dcount++;
            if (dcount > 0) post++;
        end
        go            = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("done_once",   32'(dcount),        32'd1);
        check_eq("idle_after",  32'(busy),          32'd0);
        check_eq("err_clear",   32'(err),           32'd0);
        check_eq("dump_count",  32'(got_q.size()),  32'(N_DUMP));
        if (got_q.size() == N_DUMP) begin
            for (int i = 0; i < int'(N_DUMP); i++)
                check_eq("dump_data", 32'(got_q[i]), 32'(res[i]));
        end
        check_eq("hold_stable",     32'(hold_bad), 32'd0);
        check_eq("own_in_start",    32'(own_bad),  32'd0);
        check_eq("we_outside_load", 32'(we_bad),   32'd0);
    endtask

    task automatic seq_body(input bit force_gap, input int start_delay, input int run_len,
                            input bit stall_second, input bit go_noise);
        load_bytes(force_gap);
        run_proc(start_delay, run_len, go_noise);
        run_dump(stall_second, go_noise);
    endtask

    task automatic full_seq(input bit force_gap, input int start_delay, input int run_len,
                            input bit stall_second, input bit go_noise);
        pulse_go();
        check_eq("go_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("go_busy",     32'(busy),         32'd1);
        seq_body(force_gap, start_delay, run_len, stall_second, go_noise);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        go              = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.proc_status = 2'b00;
        proc_we         = 1'b0;
        proc_addr       = 4'h0;
        proc_wdata      = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Directed pass: known bytes, a valid gap, delayed run, stalled 2nd byte, go noise.
        src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        res = '{8'h11, 8'h22, 8'h33};
        full_seq(1'b1, 3, 5, 1'b1, 1'b1);

        // Start timeout: processor never reports running.
        rand_data();
        pulse_go();
        load_bytes(1'b0);
        repeat (START_TIMEOUT - 1) tick();
        check_eq("tmo_pre_status", 32'(bus.status), 32'd1);
        check_eq("tmo_pre_err",    32'(err),        32'd0);
        tick();
        check_eq("tmo_err",      32'(err),          32'd1);
        check_eq("tmo_status",   32'(bus.status),   32'd0);
        check_eq("tmo_host_own", 32'(bus.host_own), 32'd1);
        check_eq("tmo_busy",     32'(busy),         32'd1);
        tick();
        check_eq("tmo_idle",   32'(busy), 32'd0);
        check_eq("tmo_sticky", 32'(err),  32'd1);
        tick();
        check_eq("tmo_sticky2", 32'(err), 32'd1);
        rand_data();
        pulse_go();
        check_eq("go_clears_err", 32'(err), 32'd0);
        seq_body(1'b0, 1, 4, 1'b0, 1'b0);

        // Reset in the middle of a load.
        rand_data();
        pulse_go();
        bus.in_valid = 1'b1;
        bus.in_data  = src[0];
        tick();
        bus.in_data  = src[1];
        tick();
        bus.in_data  = src[2];
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        rand_data();
        full_seq(1'b0, 0, 3, 1'b1, 1'b0);

        // Randomized passes.
        for (int n = 0; n < 5; n++) begin
            rand_data();
            full_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                     int'($urandom_range(3, 8)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
